// File: rtl/vx_mem_slave_pkg.sv
// vx_mem_slave_pkg: shared widths and the response-entry type for the
// Vortex memory slave and its response FIFO.
package vx_mem_slave_pkg;

  localparam int VX_DATA_W     = 512;  // line width in bits
  localparam int VX_ADDR_W     = 26;   // line address width
  localparam int VX_TAG_W      = 56;   // request tag width
  localparam int VX_MEM_LINES  = 1024; // 64 KiB of line storage
  localparam int VX_RSP_LAT    = 2;    // read latency, accept to visible
  localparam int VX_FIFO_DEPTH = 4;    // outstanding read credits

  // One queued read response; tag travels alongside its line data.
  typedef struct packed {
    logic [VX_TAG_W-1:0]  tag;
    logic [VX_DATA_W-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/vx_mem_slave_rsp_fifo.sv
// vx_mem_slave_rsp_fifo: small synchronous FIFO of read responses.
// The head entry is shown combinationally from storage, so an entry pushed on
// one edge is visible right after that edge. The caller guarantees no push
// while full (credit counted upstream).
module vx_mem_slave_rsp_fifo
  import vx_mem_slave_pkg::*;
#(
  parameter int DEPTH = VX_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  rsp_entry_t push_entry,
  input  logic       pop,
  output logic       out_valid,
  output rsp_entry_t out_entry
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rsp_entry_t       slot_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_pop_s;

  // Wrap a pointer at DEPTH so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign do_pop_s  = pop & (count_r != '0);
  assign out_valid = (count_r != '0);
  assign out_entry = slot_r[rd_ptr_r];

  // Storage, pointers and occupancy; reset empties the queue and zeroes the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        slot_r[wr_ptr_r] <= push_entry;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/vortex_mem_slave.sv
// vortex_mem_slave: line-wide memory behind the Vortex memory interface plus
// a 32-bit side bus port sharing the same storage. Vortex requests win the
// storage; a bus access in the same cycle is dropped and stalled for retry.
// Optional build macro VX_MEM_SLAVE_OOB_EN: out-of-range addresses drop
// writes, read as zero and pulse addr_oob; without it addresses wrap.
// MEM_LINES is expected to be a power of two; DATA_W/TAG_W must match the
// package so the response entry type lines up.
module vortex_mem_slave
  import vx_mem_slave_pkg::*;
#(
  parameter int DATA_W     = VX_DATA_W,
  parameter int ADDR_W     = VX_ADDR_W,
  parameter int TAG_W      = VX_TAG_W,
  parameter int BYTEEN_W   = DATA_W / 8,
  parameter int MEM_LINES  = VX_MEM_LINES,
  parameter int RSP_LAT    = VX_RSP_LAT,
  parameter int FIFO_DEPTH = VX_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_req_valid,
  input  logic                mem_req_rw,
  input  logic [BYTEEN_W-1:0] mem_req_byteen,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic [DATA_W-1:0]   mem_req_data,
  input  logic [TAG_W-1:0]    mem_req_tag,
  output logic                mem_req_ready,
  output logic                mem_rsp_valid,
  output logic [DATA_W-1:0]   mem_rsp_data,
  output logic [TAG_W-1:0]    mem_rsp_tag,
  input  logic                mem_rsp_ready,
  input  logic                busy,
  input  logic [31:0]         bus_addr,
  input  logic                bus_ren,
  input  logic                bus_wen,
  input  logic [31:0]         bus_wdata,
  input  logic [3:0]          bus_strobe,
  output logic [31:0]         bus_rdata,
  output logic                bus_request_stall,
  output logic                addr_oob
);

  localparam int LINE_AW = $clog2(MEM_LINES);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PIPE_N  = RSP_LAT - 1; // stages before the FIFO write

  logic [DATA_W-1:0]  mem_r [MEM_LINES];
  logic               mem_req_ready_r;
  logic [CNT_W-1:0]   used_r;
  logic [CNT_W-1:0]   used_next_s;
  logic [PIPE_N-1:0]  pipe_vld_r;
  rsp_entry_t         pipe_ent_r [PIPE_N];
  rsp_entry_t         rd_entry_s;
  rsp_entry_t         rsp_head_s;
  logic [31:0]        bus_rdata_r;
  logic               addr_oob_r;
  logic               req_fire_s;
  logic               rd_fire_s;
  logic               wr_fire_s;
  logic               rsp_pop_s;
  logic               bus_act_s;
  logic               req_oob_s;
  logic               bus_oob_s;
  logic [LINE_AW-1:0] req_line_s;
  logic [LINE_AW-1:0] bus_line_s;
  logic [3:0]         bus_word_s;
  logic [31:0]        bus_word_data_s;
  logic               unused_ok_s;

  assign req_fire_s = mem_req_valid & mem_req_ready_r;
  assign rd_fire_s  = req_fire_s & ~mem_req_rw;
  assign wr_fire_s  = req_fire_s & mem_req_rw;
  assign rsp_pop_s  = mem_rsp_valid & mem_rsp_ready;
  assign bus_act_s  = (bus_ren | bus_wen) & ~req_fire_s;

  assign req_line_s = mem_req_addr[LINE_AW-1:0];
  assign bus_line_s = bus_addr[LINE_AW+5:6];
  assign bus_word_s = bus_addr[5:2];

`ifdef VX_MEM_SLAVE_OOB_EN
  assign req_oob_s = (mem_req_addr >= ADDR_W'(MEM_LINES));
  assign bus_oob_s = (bus_addr[31:2] >= 30'(16 * MEM_LINES));
`else
  assign req_oob_s = 1'b0;
  assign bus_oob_s = 1'b0;
`endif

  // busy is status only; upper address bits only matter for bounds checks.
  assign unused_ok_s = ^{busy, mem_req_addr, bus_addr};

  assign rd_entry_s.tag   = mem_req_tag;
  assign rd_entry_s.data  = req_oob_s ? '0 : mem_r[req_line_s];
  assign bus_word_data_s  = mem_r[bus_line_s][{bus_word_s, 5'd0} +: 32];

  assign mem_req_ready     = mem_req_ready_r;
  assign bus_request_stall = req_fire_s;
  assign bus_rdata         = bus_rdata_r;
  assign addr_oob          = addr_oob_r;
  assign mem_rsp_data      = rsp_head_s.data;
  assign mem_rsp_tag       = rsp_head_s.tag;

  // Storage writes; contents survive reset. Vortex and bus never write together.
  always_ff @(posedge clk) begin
    if (wr_fire_s && !req_oob_s) begin
      for (int i = 0; i < BYTEEN_W; i++) begin
        if (mem_req_byteen[i]) begin
          mem_r[req_line_s][i*8 +: 8] <= mem_req_data[i*8 +: 8];
        end
      end
    end else if (bus_act_s && bus_wen && !bus_oob_s) begin
      for (int j = 0; j < 4; j++) begin
        if (bus_strobe[j]) begin
          mem_r[bus_line_s][{bus_word_s, 2'(j), 3'd0} +: 8] <= bus_wdata[j*8 +: 8];
        end
      end
    end
  end

  // Outstanding-read count after this edge: reads in flight plus queued.
  always_comb begin
    used_next_s = used_r;
    case ({rd_fire_s, rsp_pop_s})
      2'b10:   used_next_s = used_r + CNT_W'(1);
      2'b01:   used_next_s = used_r - CNT_W'(1);
      default: used_next_s = used_r;
    endcase
  end

  // Credit counter and registered ready; ready stays low while in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      used_r          <= '0;
      mem_req_ready_r <= 1'b0;
    end else begin
      used_r          <= used_next_s;
      mem_req_ready_r <= (used_next_s != CNT_W'(FIFO_DEPTH));
    end
  end

  // Read latency pipeline feeding the response FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < PIPE_N; i++) begin
        pipe_ent_r[i] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= rd_fire_s;
      pipe_ent_r[0] <= rd_entry_s;
      for (int i = 1; i < PIPE_N; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_ent_r[i] <= pipe_ent_r[i-1];
      end
    end
  end

  // Bus read data (pre-write value on simultaneous ren/wen) and bounds pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_rdata_r <= '0;
      addr_oob_r  <= 1'b0;
    end else begin
      if (bus_act_s && bus_ren) begin
        bus_rdata_r <= bus_oob_s ? 32'h0000_0000 : bus_word_data_s;
      end
      addr_oob_r <= (req_fire_s & req_oob_s) | (bus_act_s & bus_oob_s);
    end
  end

  vx_mem_slave_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (pipe_vld_r[PIPE_N-1]),
    .push_entry (pipe_ent_r[PIPE_N-1]),
    .pop        (rsp_pop_s),
    .out_valid  (mem_rsp_valid),
    .out_entry  (rsp_head_s)
  );

endmodule

// File: tb/tb_vortex_mem_slave.sv
// tb_vortex_mem_slave: directed and randomized checks of vortex_mem_slave
// against a queue/array reference model of the memory and response stream.
module tb_vortex_mem_slave;

  localparam int FIFO_DEPTH = 4;
`ifdef VX_MEM_SLAVE_OOB_EN
  localparam bit OOB_ON = 1'b1;
`else
  localparam bit OOB_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [63:0]  mem_req_byteen;
  logic [25:0]  mem_req_addr;
  logic [511:0] mem_req_data;
  logic [55:0]  mem_req_tag;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [511:0] mem_rsp_data;
  logic [55:0]  mem_rsp_tag;
  logic         mem_rsp_ready;
  logic         busy;
  logic [31:0]  bus_addr;
  logic         bus_ren;
  logic         bus_wen;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_strobe;
  logic [31:0]  bus_rdata;
  logic         bus_request_stall;
  logic         addr_oob;

  typedef struct {
    logic [55:0]  tag;
    logic [511:0] data;
    int           vis;
  } rsp_exp_t;

  rsp_exp_t     exp_q [$];
  logic [511:0] mdl_mem [1024];
  logic [31:0]  exp_rdata;
  logic         exp_oob;
  int           cyc;
  int           n_vec;
  int           n_err;
  logic         m_fire;
  logic         s_ready;
  logic         s_stall;
  logic         s_rsp_valid;
  logic [511:0] s_rsp_data;
  logic [55:0]  s_rsp_tag;

  vortex_mem_slave dut (
    .clk               (clk),
    .reset             (reset),
    .mem_req_valid     (mem_req_valid),
    .mem_req_rw        (mem_req_rw),
    .mem_req_byteen    (mem_req_byteen),
    .mem_req_addr      (mem_req_addr),
    .mem_req_data      (mem_req_data),
    .mem_req_tag       (mem_req_tag),
    .mem_req_ready     (mem_req_ready),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .mem_rsp_tag       (mem_rsp_tag),
    .mem_rsp_ready     (mem_rsp_ready),
    .busy              (busy),
    .bus_addr          (bus_addr),
    .bus_ren           (bus_ren),
    .bus_wen           (bus_wen),
    .bus_wdata         (bus_wdata),
    .bus_strobe        (bus_strobe),
    .bus_rdata         (bus_rdata),
    .bus_request_stall (bus_request_stall),
    .addr_oob          (addr_oob)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic idle_inputs();
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    bus_ren       = 1'b0;
    bus_wen       = 1'b0;
    mem_rsp_ready = 1'b1;
  endtask

  task automatic set_read(input logic [25:0] a, input logic [55:0] t);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = a;
    mem_req_tag   = t;
  endtask

  task automatic set_write(input logic [25:0] a, input logic [63:0] be, input logic [511:0] d);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = a;
    mem_req_byteen = be;
    mem_req_data   = d;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model across
  // the edge, then check registered bus outputs just after the edge.
  task automatic run_cycle();
    logic exp_ready, exp_valid, pop, bact, roob, boob, nxt_oob;
    int   rl, bl, bw;
    @(negedge clk);
    s_ready     = mem_req_ready;
    s_stall     = bus_request_stall;
    s_rsp_valid = mem_rsp_valid;
    s_rsp_data  = mem_rsp_data;
    s_rsp_tag   = mem_rsp_tag;
    exp_ready   = (exp_q.size() < FIFO_DEPTH);
    exp_valid   = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    check_val("req_ready", 512'(s_ready), 512'(exp_ready));
    check_val("rsp_valid", 512'(s_rsp_valid), 512'(exp_valid));
    if (exp_valid) begin
      check_val("rsp_data", s_rsp_data, exp_q[0].data);
      check_val("rsp_tag", 512'(s_rsp_tag), 512'(exp_q[0].tag));
    end
    m_fire = mem_req_valid && exp_ready;
    check_val("bus_stall", 512'(s_stall), 512'(m_fire));
    pop  = exp_valid && mem_rsp_ready;
    bact = (bus_ren || bus_wen) && !m_fire;
    roob = OOB_ON && (mem_req_addr >= 26'd1024);
    boob = OOB_ON && ((bus_addr >> 2) >= 32'd16384);
    rl   = int'(mem_req_addr % 26'd1024);
    bl   = int'((bus_addr >> 6) % 32'd1024);
    bw   = int'((bus_addr >> 2) % 32'd16);
    nxt_oob = (m_fire && roob) || (bact && boob);
    if (pop) void'(exp_q.pop_front());
    if (m_fire && !mem_req_rw) begin
      exp_q.push_back('{tag: mem_req_tag, data: (roob ? 512'd0 : mdl_mem[rl]), vis: cyc + 2});
    end
    if (m_fire && mem_req_rw && !roob) begin
      for (int i = 0; i < 64; i++)
        if (mem_req_byteen[i]) mdl_mem[rl][i*8 +: 8] = mem_req_data[i*8 +: 8];
    end
    if (bact && bus_ren) exp_rdata = boob ? 32'd0 : mdl_mem[bl][bw*32 +: 32];
    if (bact && bus_wen && !boob) begin
      for (int j = 0; j < 4; j++)
        if (bus_strobe[j]) mdl_mem[bl][bw*32 + j*8 +: 8] = bus_wdata[j*8 +: 8];
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_oob = nxt_oob;
    check_val("bus_rdata", 512'(bus_rdata), 512'(exp_rdata));
    check_val("addr_oob", 512'(addr_oob), 512'(exp_oob));
  endtask

  task automatic drain();
    idle_inputs();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) run_cycle();
    check_val("drain_left", 512'(exp_q.size()), 512'(0));
    check_val("drain_idle", 512'(mem_rsp_valid), 512'(1'b0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    exp_rdata = 32'd0; exp_oob = 1'b0;
    for (int l = 0; l < 1024; l++) mdl_mem[l] = '0;
    reset = 1'b1; busy = 1'b0;
    mem_req_byteen = '0; mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0;
    bus_addr = '0; bus_wdata = '0; bus_strobe = '0;
    idle_inputs();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rsp_valid", 512'(mem_rsp_valid), 512'(1'b0));
    check_val("rst_rsp_data", mem_rsp_data, 512'd0);
    check_val("rst_rsp_tag", 512'(mem_rsp_tag), 512'd0);
    check_val("rst_bus_rdata", 512'(bus_rdata), 512'd0);
    check_val("rst_stall", 512'(bus_request_stall), 512'(1'b0));
    check_val("rst_oob", 512'(addr_oob), 512'(1'b0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    check_val("rst_ready", 512'(mem_req_ready), 512'(1'b1));

    // Give the lines used below known contents.
    for (int l = 0; l < 32; l++) begin
      set_write(26'(l), {64{1'b1}}, rand_line());
      run_cycle();
    end

    // Write 0xA5 to line 0x10, read it back with tag 7, two cycles latency.
    drain();
    set_write(26'h10, {64{1'b1}}, {64{8'hA5}});
    run_cycle();
    set_read(26'h10, 56'd7);
    run_cycle();
    idle_inputs();
    mem_rsp_ready = 1'b0;
    run_cycle();
    check_val("lat_early", 512'(s_rsp_valid), 512'(1'b0));
    mem_rsp_ready = 1'b1;
    run_cycle();
    check_val("lat_valid", 512'(s_rsp_valid), 512'(1'b1));
    check_val("lat_data", s_rsp_data, {64{8'hA5}});
    check_val("lat_tag", 512'(s_rsp_tag), 512'd7);

    // Bus read of byte address 0x400 lands in line 0x10, word 0.
    idle_inputs();
    bus_ren = 1'b1;
    bus_addr = 32'h0000_0400;
    run_cycle();
    check_val("bus_a5", 512'(bus_rdata), 512'(32'hA5A5A5A5));

    // Vortex request collides with a bus read: stalled, then retried.
    set_read(26'h10, 56'd9);
    bus_ren = 1'b1;
    bus_addr = 32'h0000_00C8;
    run_cycle();
    check_val("arb_stall", 512'(s_stall), 512'(1'b1));
    check_val("arb_hold", 512'(bus_rdata), 512'(32'hA5A5A5A5));
    mem_req_valid = 1'b0;
    run_cycle();
    check_val("arb_retry", 512'(bus_rdata), 512'(mdl_mem[3][64 +: 32]));
    drain();

    // Six reads with responses blocked: only four credits.
    mem_rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_read(26'(k), 56'(20 + k));
      run_cycle();
      if (k >= 4) check_val("credit_full", 512'(s_ready), 512'(1'b0));
    end
    mem_rsp_ready = 1'b1;
    for (int k = 4; k < 6; k++) begin
      set_read(26'(k), 56'(20 + k));
      for (int w = 0; w < 10; w++) begin
        run_cycle();
        if (m_fire) break;
      end
      check_val("credit_retry", 512'(m_fire), 512'(1'b1));
    end
    drain();

    // Randomized mixed traffic.
    for (int n = 0; n < 400; n++) begin
      int line, bline;
      line  = $urandom_range(0, 31);
      bline = $urandom_range(0, 31);
      mem_req_valid  = ($urandom_range(0, 99) < 50);
      mem_req_rw     = $urandom_range(0, 1) == 1;
      mem_req_addr   = 26'(line + (($urandom_range(0, 15) == 0) ? 1024 : 0));
      mem_req_byteen = {$urandom(), $urandom()};
      mem_req_data   = rand_line();
      mem_req_tag    = 56'({$urandom(), $urandom()});
      mem_rsp_ready  = ($urandom_range(0, 99) < 70);
      busy           = $urandom_range(0, 1) == 1;
      bus_ren        = ($urandom_range(0, 3) == 0);
      bus_wen        = ($urandom_range(0, 3) == 0);
      bus_addr       = 32'(bline * 64 + $urandom_range(0, 63))
                     + (($urandom_range(0, 15) == 0) ? 32'h0001_0000 : 32'h0);
      bus_wdata      = $urandom();
      bus_strobe     = 4'($urandom_range(0, 15));
      run_cycle();
    end
    drain();

    // Line 0x400: out of range when bounds checking is built in, else line 0.
    set_read(26'h400, 56'h33);
    run_cycle();
    check_val("oob_pulse", 512'(addr_oob), 512'(OOB_ON));
    idle_inputs();
    run_cycle();
    check_val("oob_clear", 512'(addr_oob), 512'(1'b0));
    drain();

    // Reset in the middle of a read burst discards responses, keeps memory.
    mem_rsp_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      set_read(26'(k), 56'(100 + k));
      run_cycle();
    end
    idle_inputs();
    mem_rsp_ready = 1'b0;
    run_cycle();
    check_val("burst_valid", 512'(s_rsp_valid), 512'(1'b1));
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", 512'(mem_rsp_valid), 512'(1'b0));
    check_val("mid_rst_tag", 512'(mem_rsp_tag), 512'd0);
    check_val("mid_rst_data", mem_rsp_data, 512'd0);
    check_val("mid_rst_rdata", 512'(bus_rdata), 512'd0);
    exp_q.delete();
    exp_rdata = 32'd0;
    exp_oob = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc += 3;
    check_val("mid_rst_ready", 512'(mem_req_ready), 512'(1'b1));
    mem_rsp_ready = 1'b1;
    set_read(26'd2, 56'h77);
    run_cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vortex_mem_slave.md
VORTEX_MEM_SLAVE -- requirements
Module: vortex_mem_slave

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports named clk and reset.
REQ-002 SHALL have parameters: DATA_W 512 (line width, bits); ADDR_W 26 (line address); TAG_W 56 (request tag); BYTEEN_W DATA_W/8; MEM_LINES 1024 (64 KiB); RSP_LAT 2 (read latency, cycles); FIFO_DEPTH 4.
REQ-003 clk  in  1  clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 mem_req_valid  in  1  Vortex request valid.
REQ-006 mem_req_rw  in  1  1=write, 0=read.
REQ-007 mem_req_byteen  in  BYTEEN_W  write byte enables.
REQ-008 mem_req_addr  in  ADDR_W  line address.
REQ-009 mem_req_data  in  DATA_W  write data.
REQ-010 mem_req_tag  in  TAG_W  request tag.
REQ-011 mem_req_ready  out  1  request accepted when valid&ready.
REQ-012 mem_rsp_valid / mem_rsp_data / mem_rsp_tag  out  1 / DATA_W / TAG_W  read response.
REQ-013 mem_rsp_ready  in  1  Vortex accepts response.
REQ-014 busy  in  1  Vortex busy status; monitor only, no functional effect.
REQ-015 bus_addr  in  32  byte address; bus_ren, bus_wen  in  1; bus_wdata  in  32; bus_strobe  in  4.
REQ-016 bus_rdata  out  32; bus_request_stall  out  1; addr_oob  out  1 (out-of-bounds pulse).

Function
REQ-017 Storage: MEM_LINES x DATA_W array; 32-bit word w = bus_addr[15:2] maps to line w/16, bytes (w%16)*4..+3, little-endian.
REQ-018 Vortex write: on valid&ready&rw, write bytes where byteen[i]=1; no response generated.
REQ-019 Vortex read: on valid&ready&!rw, line data and tag enter response FIFO, becoming visible on mem_rsp_* exactly RSP_LAT cycles after acceptance when FIFO ahead is empty.
REQ-020 Responses SHALL return in request order; mem_rsp_valid/data/tag held stable until mem_rsp_ready.
REQ-021 mem_req_ready=0 when in-flight reads plus FIFO occupancy equal FIFO_DEPTH; otherwise 1.
REQ-022 Read-after-write to same line in consecutive accepted requests SHALL return written data.
REQ-023 Bus port: bus_ren -> bus_rdata registered, valid the cycle after; bus_wen writes bytes where bus_strobe set.
REQ-024 Arbitration: in a cycle where a Vortex request is accepted, bus access is ignored and bus_request_stall=1; bus master retries.
REQ-025 bus_ren and bus_wen both high: write performed, bus_rdata returns pre-write data.

Reset
REQ-026 Reset SHALL clear FIFO and pipeline, drive mem_rsp_valid=0, mem_rsp_data=0, mem_rsp_tag=0, bus_rdata=0, bus_request_stall=0, addr_oob=0; mem_req_ready=1 after release.
REQ-027 Reset mid-operation SHALL discard outstanding responses; memory contents SHALL be unaffected (initialized to zero at time zero).

Configuration
REQ-028 With VX_MEM_SLAVE_OOB_EN defined: line address >= MEM_LINES (or bus word >= 16*MEM_LINES) -> writes dropped, reads return zero, addr_oob pulses 1 cycle.
REQ-029 Without VX_MEM_SLAVE_OOB_EN: addresses wrap modulo MEM_LINES; addr_oob tied 0.

Structure
REQ-030 Package vx_mem_slave_pkg SHALL hold width constants and rsp_entry_t typedef {tag, data}.
REQ-031 One sub-module vx_mem_slave_rsp_fifo (synchronous FIFO, FIFO_DEPTH entries of rsp_entry_t).

Verification
REQ-032 Write line 0x10 all-ones byteen data 0xA5.., then read tag 7 -> response data 0xA5.., tag 7, 2 cycles after accept.
REQ-033 Bus read bus_addr 0x400 after REQ-032 -> bus_rdata 0xA5A5A5A5 next cycle.
REQ-034 Issue 6 reads with mem_rsp_ready=0 -> mem_req_ready drops after 4; responses drain in order when ready=1.
REQ-035 Simultaneous Vortex request and bus_ren -> bus_request_stall=1 that cycle, bus read succeeds on retry.
REQ-036 OOB_EN: read line 0x400 -> data 0, addr_oob pulse; assert reset mid-burst -> mem_rsp_valid=0 immediately.
